rr_arb16: RTL and testbench

RR_ARB16 -- requirements
Module: rr_arb16

---
 rtl/rr_arb16.sv | 130 +++++++++++++
 tb/tb_rr_arb16.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb16.sv
// rr_arb16: 16-way round-robin arbiter with per-grant hold limit driving a 16:1 data mux; 1-cycle request-to-grant.
// Optional macro RR_ARB_LOCK_EN adds a lock input that suppresses the hold-limit release.
module rr_arb16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef RR_ARB_LOCK_EN
    input  logic        lock,
`endif
    input  logic [15:0] req,
    input  logic [15:0] din,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        gnt_valid,
    output logic        dout
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [3:0]  hcnt, hcnt_n;
    logic [15:0] gnt_n;
    logic [3:0]  sel_n;
    logic        vld_n;

    logic [3:0]  base;
    logic [3:0]  sel_inc;
    logic        pick_found;
    logic [3:0]  pick_idx;
    logic        cur_req;
    logic        at_max;
    logic        lock_hold;
    logic        release_now;

    // First set bit of r at or after base, wrapping modulo 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] b);
        logic [31:0] dbl;
        logic [3:0]  off;
        logic        found;
        dbl   = {r, r} >> b;
        off   = 4'd0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (dbl[i]) begin
                off   = 4'(i);
                found = 1'b1;
            end
        end
        return {found, 4'(b + off)};
    endfunction

    assign sel_inc = 4'(sel + 4'd1);
    assign base    = (state == GRANT) ? sel_inc : ptr;
    assign {pick_found, pick_idx} = rr_pick(req, base);
    assign cur_req = req[sel];
    assign at_max  = (hcnt == HOLD_LIM);

`ifdef RR_ARB_LOCK_EN
    assign lock_hold = lock & cur_req;
`else
    assign lock_hold = 1'b0;
`endif

    assign release_now = !cur_req || (at_max && !lock_hold);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        gnt_n   = gnt;
        sel_n   = sel;
        vld_n   = gnt_valid;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANT;
                    sel_n   = pick_idx;
                    gnt_n   = 16'd1 << pick_idx;
                    vld_n   = 1'b1;
                    hcnt_n  = 4'd1;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    // Saturates only when lock keeps the grant past the limit.
                    hcnt_n = at_max ? hcnt : 4'(hcnt + 4'd1);
                end else begin
                    ptr_n = sel_inc;
                    if (pick_found) begin
                        sel_n  = pick_idx;
                        gnt_n  = 16'd1 << pick_idx;
                        vld_n  = 1'b1;
                        hcnt_n = 4'd1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 16'd0;
                        vld_n   = 1'b0;
                        hcnt_n  = 4'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 4'd0;
            hcnt      <= 4'd0;
            gnt       <= 16'd0;
            sel       <= 4'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hcnt      <= hcnt_n;
            gnt       <= gnt_n;
            sel       <= sel_n;
            gnt_valid <= vld_n;
        end
    end

    assign dout = gnt_valid & din[sel];

endmodule

// File: tb/tb_rr_arb16.sv
// Directed bench for rr_arb16: three instances (MAX_HOLD 8, 4, 1) share one stimulus stream.
module tb_rr_arb16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b0;
    logic [15:0] req = 16'd0;
    logic [15:0] din = 16'd0;

    logic [15:0] gnt8, gnt4, gnt1;
    logic [3:0]  sel8, sel4, sel1;
    logic        vld8, vld4, vld1;
    logic        dout8, dout4, dout1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arb16 #(.MAX_HOLD(8)) u8 (
        .clk(clk), .rst_n(rst_n),
`ifdef RR_ARB_LOCK_EN
        .lock(lock),
`endif
        .req(req), .din(din), .gnt(gnt8), .sel(sel8), .gnt_valid(vld8), .dout(dout8));

    rr_arb16 #(.MAX_HOLD(4)) u4 (
        .clk(clk), .rst_n(rst_n),
`ifdef RR_ARB_LOCK_EN
        .lock(lock),
`endif
        .req(req), .din(din), .gnt(gnt4), .sel(sel4), .gnt_valid(vld4), .dout(dout4));

    rr_arb16 #(.MAX_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n),
`ifdef RR_ARB_LOCK_EN
        .lock(lock),
`endif
        .req(req), .din(din), .gnt(gnt1), .sel(sel1), .gnt_valid(vld1), .dout(dout1));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output check of the MAX_HOLD=8 instance against an expected grant index or idle.
    task automatic chk8(input string tag, input logic exp_vld, input logic [3:0] exp_sel);
        logic [15:0] one;
        one = 16'd1;
        chk({tag, "_vld"}, {15'd0, vld8}, {15'd0, exp_vld});
        chk({tag, "_sel"}, {12'd0, sel8}, {12'd0, exp_sel});
        chk({tag, "_gnt"}, gnt8, exp_vld ? (one << exp_sel) : 16'd0);
        chk({tag, "_dout"}, {15'd0, dout8}, {15'd0, exp_vld & din[exp_sel]});
    endtask

    initial begin
        logic [15:0] one;
        int e8, e4, e1;
        one = 16'd1;

        // Reset state
        tick();
        tick();
        chk8("reset", 1'b0, 4'd0);
        chk("reset_vld1", {15'd0, vld1}, 16'd0);
        rst_n = 1'b1;

        // Single requester 0 for three cycles
        req = 16'h0001;
        din = 16'h0001;
        tick();
        chk8("r0_c1", 1'b1, 4'd0);
        chk("r0_c1_sel1", {12'd0, sel1}, 16'd0);
        din = 16'h0000;
        #1;
        chk("r0_dout_follow", {15'd0, dout8}, 16'd0);
        tick();
        chk8("r0_c2", 1'b1, 4'd0);
        tick();
        chk8("r0_c3", 1'b1, 4'd0);
        chk("r0_c3_sel1", {12'd0, sel1}, 16'd0);
        req = 16'h0000;
        tick();
        chk8("r0_idle", 1'b0, 4'd0);
        chk("r0_idle_vld1", {15'd0, vld1}, 16'd0);

        // Grant 5, then drop 5 while 11 requests
        din = 16'h0820;
        req = 16'h0020;
        tick();
        chk8("g5", 1'b1, 4'd5);
        req = 16'h0800;
        tick();
        chk8("g11", 1'b1, 4'd11);
        chk("g11_sel4", {12'd0, sel4}, 16'd11);
        chk("g11_sel1", {12'd0, sel1}, 16'd11);
        req = 16'h0000;
        tick();
        chk8("g11_idle", 1'b0, 4'd11);

        // Reset mid-grant on 12, then requesters 0 and 12
        din = 16'h1000;
        req = 16'h1000;
        tick();
        chk8("g12", 1'b1, 4'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_rst", 1'b0, 4'd0);
        chk("async_rst_dout", {15'd0, dout8}, 16'd0);
        req = 16'h1001;
        din = 16'h1001;
        tick();
        chk8("rst_held", 1'b0, 4'd0);
        rst_n = 1'b1;
        tick();
        chk8("post_rst", 1'b1, 4'd0);
        chk("post_rst_sel1", {12'd0, sel1}, 16'd0);
        tick();
        chk8("post_rst_hold", 1'b1, 4'd0);
        chk("hold1_rot_a", {12'd0, sel1}, 16'd12);
        chk("hold1_rot_a_gnt", gnt1, 16'h1000);
        tick();
        chk("hold1_rot_b", {12'd0, sel1}, 16'd0);
        chk("hold4_keep", {12'd0, sel4}, 16'd0);
        req = 16'h0000;
        tick();
        chk8("post_rst_idle", 1'b0, 4'd0);

        // Sole requester 9 held 20 cycles
        din = 16'h0200;
        req = 16'h0200;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("sole9_vld4", {15'd0, vld4}, 16'd1);
            chk("sole9_sel4", {12'd0, sel4}, 16'd9);
            chk("sole9_sel1", {12'd0, sel1}, 16'd9);
            chk("sole9_dout4", {15'd0, dout4}, 16'd1);
        end
        chk8("sole9_end", 1'b1, 4'd9);
        req = 16'h0000;
        tick();
        chk("sole9_idle4", {15'd0, vld4}, 16'd0);

        // All sixteen requesting from ptr=0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 16'hFFFF;
        for (int c = 0; c < 136; c++) begin
            din = 16'($urandom);
            tick();
            e8 = (c / 8) % 16;
            e4 = (c / 4) % 16;
            e1 = c % 16;
            chk("rot_sel8", {12'd0, sel8}, 16'(e8));
            chk("rot_gnt8", gnt8, one << e8);
            chk("rot_vld8", {15'd0, vld8}, 16'd1);
            chk("rot_dout8", {15'd0, dout8}, {15'd0, din[e8]});
            chk("rot_sel4", {12'd0, sel4}, 16'(e4));
            chk("rot_gnt1", gnt1, one << e1);
        end
        req = 16'h0000;
        tick();
        chk8("rot_idle", 1'b0, 4'd0);

`ifdef RR_ARB_LOCK_EN
        // Lock keeps requester 0 past the hold limit
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        lock = 1'b1;
        din = 16'h0003;
        req = 16'h0003;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("lock_sel8", {12'd0, sel8}, 16'd0);
            chk("lock_vld8", {15'd0, vld8}, 16'd1);
        end
        lock = 1'b0;
        tick();
        chk8("unlock", 1'b1, 4'd1);
        req = 16'h0000;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
